// File: rtl/flex_updown_counter_if.sv
// Control and status bundle for flex_updown_counter.
// master drives clear/load/step controls; slave returns count and flags.
interface flex_updown_counter_if #(
  parameter int NUM_CNT_BITS = 4
);
  logic                    clear;
  logic                    load;
  logic [NUM_CNT_BITS-1:0] load_val;
  logic                    count_enable;
  logic                    count_down;
  logic [NUM_CNT_BITS-1:0] rollover_val;
  logic [NUM_CNT_BITS-1:0] count_out;
  logic                    rollover_flag;
  logic                    bottom_flag;
  logic                    wrap_pulse;

  modport master (
    output clear,
    output load,
    output load_val,
    output count_enable,
    output count_down,
    output rollover_val,
    input  count_out,
    input  rollover_flag,
    input  bottom_flag,
    input  wrap_pulse
  );

  modport slave (
    input  clear,
    input  load,
    input  load_val,
    input  count_enable,
    input  count_down,
    input  rollover_val,
    output count_out,
    output rollover_flag,
    output bottom_flag,
    output wrap_pulse
  );
endinterface

// File: rtl/flex_updown_counter.sv
// Up/down counter, range 1..rollover_val, wrap or saturate, with load.
// Ports: clk, n_rst (async low), bus (slave: controls in, count/flags out).
module flex_updown_counter #(
  parameter int NUM_CNT_BITS = 4,
  parameter bit SATURATE     = 1'b0
) (
  input  logic                  clk,
  input  logic                  n_rst,
  flex_updown_counter_if.slave  bus
);

  localparam logic [NUM_CNT_BITS-1:0] ZERO = '0;
  localparam logic [NUM_CNT_BITS-1:0] ONE  =
    NUM_CNT_BITS'(1);

  logic [NUM_CNT_BITS-1:0] cnt_q;
  logic [NUM_CNT_BITS-1:0] cnt_d;
  logic [NUM_CNT_BITS-1:0] rv;
  logic                    roll_q;
  logic                    roll_d;
  logic                    bot_q;
  logic                    bot_d;
  logic                    wrap_q;
  logic                    wrap_d;
  logic                    step;

  assign rv   = bus.rollover_val;
  assign step = bus.count_enable && (rv != ZERO);

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    priority case (1'b1)
      bus.clear: cnt_d = ZERO;
      bus.load:  cnt_d = bus.load_val;
      step: begin
        if (!bus.count_down) begin
          // >= rather than == so overruns from a load
          // or a lowered top also fold back to 1.
          if (cnt_q < rv) begin
            cnt_d = cnt_q + ONE;
          end else if (SATURATE == 1'b0) begin
            cnt_d  = ONE;
            wrap_d = 1'b1;
          end
        end else begin
          // Above the top, a down step clamps to it.
          if (cnt_q > rv) begin
            cnt_d = rv;
          end else if (cnt_q > ONE) begin
            cnt_d = cnt_q - ONE;
          end else if (SATURATE == 1'b0) begin
            cnt_d  = rv;
            wrap_d = 1'b1;
          end
        end
      end
      default: cnt_d = cnt_q;
    endcase
  end

  // Flags follow the next count so they line up
  // with count_out; clear forces them low.
  assign roll_d = !bus.clear && (cnt_d == rv);
  assign bot_d  = !bus.clear && (cnt_d == ONE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q  <= ZERO;
      roll_q <= 1'b0;
      bot_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      roll_q <= roll_d;
      bot_q  <= bot_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.count_out     = cnt_q;
  assign bus.rollover_flag = roll_q;
  assign bus.bottom_flag   = bot_q;
  assign bus.wrap_pulse    = wrap_q;

endmodule

// File: tb/tb_flex_updown_counter.sv
// Directed bench for flex_updown_counter.
// Three instances: 4-bit wrap, 4-bit saturate, 8-bit wrap.
module tb_flex_updown_counter;

  logic tb_clk;
  logic tb_n_rst;
  int   total;
  int   bad;

  flex_updown_counter_if #(.NUM_CNT_BITS(4)) a ();
  flex_updown_counter_if #(.NUM_CNT_BITS(4)) s ();
  flex_updown_counter_if #(.NUM_CNT_BITS(8)) w ();

  flex_updown_counter #(
    .NUM_CNT_BITS(4),
    .SATURATE(1'b0)
  ) u_a (
    .clk(tb_clk),
    .n_rst(tb_n_rst),
    .bus(a)
  );

  flex_updown_counter #(
    .NUM_CNT_BITS(4),
    .SATURATE(1'b1)
  ) u_s (
    .clk(tb_clk),
    .n_rst(tb_n_rst),
    .bus(s)
  );

  flex_updown_counter #(
    .NUM_CNT_BITS(8),
    .SATURATE(1'b0)
  ) u_w (
    .clk(tb_clk),
    .n_rst(tb_n_rst),
    .bus(w)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic chk_a(
    input string       tag,
    input logic [31:0] c,
    input logic        r,
    input logic        b,
    input logic        p
  );
    chk({tag, ".cnt"}, 32'(a.count_out), c);
    chk({tag, ".roll"}, 32'(a.rollover_flag), 32'(r));
    chk({tag, ".bot"}, 32'(a.bottom_flag), 32'(b));
    chk({tag, ".wrap"}, 32'(a.wrap_pulse), 32'(p));
  endtask

  int up_c [4] = '{1, 2, 3, 1};
  bit up_r [4] = '{0, 0, 1, 0};
  bit up_b [4] = '{1, 0, 0, 1};
  bit up_p [4] = '{0, 0, 0, 1};
  int sup  [8] = '{1, 2, 3, 4, 5, 5, 5, 5};
  int sdn  [8] = '{4, 3, 2, 1, 1, 1, 1, 1};

  initial begin
    total = 0;
    bad   = 0;
    tb_n_rst = 1'b0;
    a.clear = 0; a.load = 0; a.load_val = '0;
    a.count_enable = 0; a.count_down = 0;
    a.rollover_val = '0;
    s.clear = 0; s.load = 0; s.load_val = '0;
    s.count_enable = 0; s.count_down = 0;
    s.rollover_val = '0;
    w.clear = 0; w.load = 0; w.load_val = '0;
    w.count_enable = 0; w.count_down = 0;
    w.rollover_val = '0;

    // Reset behaviour
    repeat (2) @(posedge tb_clk);
    #1;
    chk_a("rst0", 0, 0, 0, 0);
    tb_n_rst = 1'b1;
    a.rollover_val = 4'd3;
    a.count_enable = 1'b1;
    step();
    chk_a("rel1", 1, 0, 1, 0);
    step();
    chk("cnt2", 32'(a.count_out), 2);
    #2;
    tb_n_rst = 1'b0;
    #1;
    chk_a("async", 0, 0, 0, 0);
    step();
    chk_a("rsthold", 0, 0, 0, 0);
    tb_n_rst = 1'b1;
    step();
    chk_a("rel2", 1, 0, 1, 0);

    // Up wrap, top 3
    a.clear = 1'b1;
    step();
    chk_a("clr", 0, 0, 0, 0);
    a.clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_a($sformatf("up%0d", i), 32'(up_c[i]),
            up_r[i], up_b[i], up_p[i]);
    end
    a.count_enable = 1'b0;
    step();
    chk_a("hold", 1, 0, 1, 0);

    // Down wrap, top 10
    a.rollover_val = 4'd10;
    a.load_val = 4'd2;
    a.load = 1'b1;
    step();
    chk_a("ld2", 2, 0, 0, 0);
    a.load = 1'b0;
    a.count_down = 1'b1;
    a.count_enable = 1'b1;
    step();
    chk_a("dn1", 1, 0, 1, 0);
    step();
    chk_a("dn10", 10, 1, 0, 1);
    step();
    chk_a("dn9", 9, 0, 0, 0);
    a.count_enable = 1'b0;
    a.count_down = 1'b0;

    // Saturating instance, top 5
    s.rollover_val = 4'd5;
    s.count_enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("sup%0d", i),
          32'(s.count_out), 32'(sup[i]));
      chk($sformatf("supw%0d", i),
          32'(s.wrap_pulse), 0);
    end
    chk("sroll", 32'(s.rollover_flag), 1);
    s.count_down = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("sdn%0d", i),
          32'(s.count_out), 32'(sdn[i]));
      chk($sformatf("sdnw%0d", i),
          32'(s.wrap_pulse), 0);
    end
    chk("sbot", 32'(s.bottom_flag), 1);
    s.count_enable = 1'b0;

    // Priority and overrun, top 12
    a.rollover_val = 4'd12;
    a.clear = 1'b1;
    a.load = 1'b1;
    a.load_val = 4'd7;
    a.count_enable = 1'b1;
    step();
    chk_a("prio", 0, 0, 0, 0);
    a.clear = 1'b0;
    a.count_enable = 1'b0;
    a.load_val = 4'd14;
    step();
    chk_a("ld14", 14, 0, 0, 0);
    a.load = 1'b0;
    a.count_enable = 1'b1;
    step();
    chk_a("ovup", 1, 0, 1, 1);
    a.count_enable = 1'b0;
    a.load = 1'b1;
    step();
    chk_a("ld14b", 14, 0, 0, 0);
    a.load = 1'b0;
    a.count_enable = 1'b1;
    a.count_down = 1'b1;
    step();
    chk_a("ovdn", 12, 1, 0, 0);
    a.rollover_val = 4'd0;
    step();
    chk_a("rv0", 12, 0, 0, 0);
    a.count_enable = 1'b0;
    a.count_down = 1'b0;

    // 8-bit, top 255
    w.rollover_val = 8'd255;
    w.load_val = 8'd254;
    w.load = 1'b1;
    step();
    chk("w254", 32'(w.count_out), 254);
    w.load = 1'b0;
    w.count_enable = 1'b1;
    step();
    chk("w255", 32'(w.count_out), 255);
    chk("w255r", 32'(w.rollover_flag), 1);
    step();
    chk("w1", 32'(w.count_out), 1);
    chk("w1p", 32'(w.wrap_pulse), 1);
    chk("w1r", 32'(w.rollover_flag), 0);
    w.count_enable = 1'b0;
    w.load_val = 8'd99;
    w.load = 1'b1;
    step();
    w.load = 1'b0;
    w.count_enable = 1'b1;
    step();
    chk("w100", 32'(w.count_out), 100);
    #2;
    tb_n_rst = 1'b0;
    #1;
    chk("wrst", 32'(w.count_out), 0);
    chk("wrstr", 32'(w.rollover_flag), 0);
    step();
    chk("wrsth", 32'(w.count_out), 0);
    tb_n_rst = 1'b1;

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
